// File: rtl/uart_pkg.sv
// Shared types, default sizing and helpers for the paced UART transmit buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } tx_state_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_GAP_CYCLES = 26100;
    localparam int DEF_GAP_W      = 15;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_paced_if.sv
// Write-side and UART-side signals of the paced transmit buffer.
interface uart_tx_fifo_paced_if
    import uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = clog2(DEF_DEPTH)
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [AW:0]       level;
    logic              overflow;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output flush, wr_en, wr_data, tx_ready,
        input  full, empty, level, overflow, tx_valid, tx_data
    );

    modport slave (
        input  flush, wr_en, wr_data, tx_ready,
        output full, empty, level, overflow, tx_valid, tx_data
    );
endinterface

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_mem_sdp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The read register doubles as the frame register, so it clears with the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata <= '0;
        else if (clr)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end
endmodule

// File: rtl/uart_tx_fifo_paced.sv
// Paced UART transmit buffer: circular FIFO drained over valid/ready with a fixed idle gap per frame.
// States: IDLE waiting for data | PRESENT frame held on tx_data | GAP inter-frame spacing.
module uart_tx_fifo_paced
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int GAP_W      = DEF_GAP_W
) (
    input logic                 clk,
    input logic                 rst,
    uart_tx_fifo_paced_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0]      LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    tx_state_e         state, state_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [GAP_W-1:0]  timer, timer_nxt;
    logic              overflow;
    logic              tx_valid, tx_valid_nxt;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] tx_data;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    // flush outranks pushes, pops and the handshake in the cycle it is asserted
    assign push  = bus.wr_en && !full && !bus.flush;

    always_comb begin
        state_nxt    = state;
        tx_valid_nxt = tx_valid;
        timer_nxt    = timer;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.tx_ready) begin
                    if (GAP_CYCLES > 0) begin
                        tx_valid_nxt = 1'b0;
                        timer_nxt    = '0;
                        state_nxt    = GAP;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        tx_valid_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
                end
            end
            GAP: begin
                timer_nxt = timer + 1'b1;
                if (timer == GAP_LAST) begin
                    if (!empty) begin
                        pop          = 1'b1;
                        tx_valid_nxt = 1'b1;
                        state_nxt    = PRESENT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_valid_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
        if (bus.flush) pop = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            timer    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (bus.flush) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            timer    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_valid <= tx_valid_nxt;
            timer    <= timer_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (bus.wr_en && full) overflow <= 1'b1;
        end
    end

    fifo_mem_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (tx_data)
    );

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
endmodule
